bp_cce_hybrid_pending_release: RTL and testbench
================================================

BP_CCE_HYBRID_PENDING_RELEASE -- requirements
Module: bp_cce_hybrid_pending_release

Interface
REQ-001 SHALL have parameter paddr_width_p, default 40; physical address width.
REQ-002 SHALL have parameter buf_els_p, default 2; entries per source buffer (minimum 2).
REQ-003 SHALL have parameter stall_limit_p, default 64; cycles of an unaccepted write before stall_o asserts.
REQ-004 SHALL use one clock; reset is asynchronous and active-high. Ports: clk_i, reset_i.
REQ-005 SHALL have the following ports (name  direction  width  meaning):
- clk_i  in  1  clock
- reset_i  in  1  asynchronous active-high reset
- mem_done_v_i  in  1  memory-response completion valid
- mem_done_ready_and_o  out  1  ready for mem_done
- mem_done_addr_i  in  paddr_width_p  completed block address
- mem_done_bypass_hash_i  in  1  address bypasses way-group hash
- ack_done_v_i  in  1  coherence-ack completion valid
- ack_done_ready_and_o  out  1  ready for ack_done
- ack_done_addr_i  in  paddr_width_p  completed block address
- clear_v_i  in  1  pending-clear request (config/error path)
- clear_ready_and_o  out  1  ready for clear
- clear_addr_i  in  paddr_width_p  address to clear
- pending_w_v_o  out  1  pending-bit write valid
- pending_w_yumi_i  in  1  write consumed by the pending stage
- pending_w_addr_o  out  paddr_width_p  write address
- pending_w_addr_bypass_hash_o  out  1  bypass hash
- pending_up_o  out  1  always 0
- pending_down_o  out  1  decrement
- pending_clear_o  out  1  clear
- stall_o  out  1  write starved for stall_limit_p cycles
- empty_o  out  1  no buffered or in-flight writes

Function
REQ-006 SHALL buffer mem_done and ack_done in independent buf_els_p-deep FIFOs; ready_and_o = not full; accept on v & ready_and.
REQ-007 SHALL buffer clear in a 1-entry register; clear_ready_and_o = register empty.
REQ-008 SHALL drive all pending_w_* outputs from an output register; outputs stay stable while pending_w_v_o=1 and pending_w_yumi_i=0.
REQ-009 Output register SHALL load when empty, or in the same cycle its entry is yumi'd (back-to-back, one write per cycle sustained).
REQ-010 Load priority SHALL be: clear first, then round-robin between mem and ack.
REQ-011 Round-robin pointer SHALL toggle only when a mem or ack entry is loaded; reset value selects mem.
REQ-012 Clear entry SHALL set pending_clear_o=1 and pending_down_o=0. Mem/ack entries SHALL set pending_down_o=1 and pending_clear_o=0. Ack entries SHALL set bypass_hash=0.
REQ-013 Latency: an input accepted in cycle N SHALL appear on pending_w_v_o no earlier than cycle N+1; no combinational path from any *_v_i to pending_w_v_o.
REQ-014 No path from pending_w_yumi_i to any *_ready_and_o; readiness depends on registered occupancy only.
REQ-015 Stall counter SHALL increment each cycle with pending_w_v_o=1 and yumi=0, saturate at stall_limit_p, and clear on yumi or when pending_w_v_o=0. stall_o = (counter == stall_limit_p).
REQ-016 empty_o SHALL be 1 iff both FIFOs, the clear register, and the output register are empty.
REQ-017 Simultaneous arrival on all three inputs SHALL accept all three (if space) with no loss; ordering within a source is FIFO.
REQ-018 Yumi while pending_w_v_o=0 is illegal; an assertion SHALL flag it.

Reset
REQ-019 On reset_i SHALL immediately and asynchronously: empty all buffers; pending_w_v_o=0; stall_o=0; empty_o=1; ready_and outputs=1 (after release); round-robin pointer=mem; counter=0. A write in flight at reset SHALL be dropped.

Structure
REQ-020 The pending-write command struct (addr, bypass_hash, up, down, clear) SHALL be defined in bp_me_pkg for reuse by the pending stage.
REQ-021 SHALL instantiate bsg_fifo_1r1w_small for each of the mem and ack buffers; the arbiter and output register SHALL be local logic.

Verification
REQ-022 Single mem_done addr 0x8000_0040, yumi held high -> pending_w_v_o in cycle N+1 with down=1, clear=0, addr 0x8000_0040; empty_o=1 at N+2.
REQ-023 mem and ack each stream 4 entries (0x100..0x400 vs 0x1100..0x1400), yumi always 1 -> output alternates mem, ack, mem, ... with 8 writes in 8 consecutive cycles.
REQ-024 Clear at 0x2000 arrives alongside pending mem/ack traffic -> clear is written next, before any mem/ack entry; round-robin pointer unchanged.
REQ-025 yumi held 0 for 70 cycles with stall_limit_p=64 -> stall_o rises in cycle 64 of the stall, outputs stable throughout; first yumi -> stall_o=0 next cycle; FIFOs full -> ready_and=0.
REQ-026 Reset asserted mid-stream with 3 buffered entries -> pending_w_v_o=0 and empty_o=1 without a clock edge; no stale write after release.

Source files
------------

// File: rtl/bp_me_pkg.sv
// Shared types for the pending-bit write path: the write command seen by the
// pending stage, plus the arbiter's round-robin and source encodings.
package bp_me_pkg;

   // Command address width; a wider paddr_width_p is truncated into this field.
   localparam int paddr_width_gp = 40;

   typedef struct packed {
      logic [paddr_width_gp-1:0] addr;
      logic                      bypass_hash;
      logic                      up;
      logic                      down;
      logic                      clear;
   } bp_pending_w_cmd_s;

   typedef enum logic {
      e_rr_mem = 1'b0,
      e_rr_ack = 1'b1
   } bp_pending_rr_e;

   typedef enum logic [1:0] {
      e_src_none  = 2'd0,
      e_src_clear = 2'd1,
      e_src_mem   = 2'd2,
      e_src_ack   = 2'd3
   } bp_pending_src_e;

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small register-based FIFO; ready_o reflects registered occupancy only, so
// it never depends on yumi_i in the same cycle.
module bsg_fifo_1r1w_small #(
   parameter int width_p = 8,
   parameter int els_p   = 2
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   output logic               ready_o,
   input  logic [width_p-1:0] data_i,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   input  logic               yumi_i
);

   localparam int ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
   localparam int cnt_w_lp = $clog2(els_p + 1);

   logic [width_p-1:0]  mem_q [els_p];
   logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d;
   logic [ptr_w_lp-1:0] wr_ptr_q, wr_ptr_d;
   logic [cnt_w_lp-1:0] cnt_q, cnt_d;
   logic                enq, deq;

   function automatic logic [ptr_w_lp-1:0] ptr_inc(input logic [ptr_w_lp-1:0] p);
      return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
   endfunction

   assign ready_o = (cnt_q != cnt_w_lp'(els_p));
   assign v_o     = (cnt_q != '0);
   assign data_o  = mem_q[rd_ptr_q];

   always_comb begin
      enq      = v_i & ready_o;
      deq      = yumi_i & v_o;
      rd_ptr_d = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      cnt_d    = cnt_q;
      if (enq && !deq) begin
         cnt_d = cnt_q + cnt_w_lp'(1);
      end else if (deq && !enq) begin
         cnt_d = cnt_q - cnt_w_lp'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (enq) begin
         mem_q[wr_ptr_q] <= data_i;
      end
   end

endmodule

// File: rtl/bp_cce_hybrid_pending_release.sv
// Merges mem-done, ack-done and clear requests into a single registered
// stream of pending-bit writes (clear first, then round-robin mem/ack).
module bp_cce_hybrid_pending_release
   import bp_me_pkg::*;
#(
   parameter int paddr_width_p = paddr_width_gp,
   parameter int buf_els_p     = 2,
   parameter int stall_limit_p = 64
) (
   input  logic                     clk_i,
   input  logic                     reset_i,

   input  logic                     mem_done_v_i,
   output logic                     mem_done_ready_and_o,
   input  logic [paddr_width_p-1:0] mem_done_addr_i,
   input  logic                     mem_done_bypass_hash_i,

   input  logic                     ack_done_v_i,
   output logic                     ack_done_ready_and_o,
   input  logic [paddr_width_p-1:0] ack_done_addr_i,

   input  logic                     clear_v_i,
   output logic                     clear_ready_and_o,
   input  logic [paddr_width_p-1:0] clear_addr_i,

   output logic                     pending_w_v_o,
   input  logic                     pending_w_yumi_i,
   output logic [paddr_width_p-1:0] pending_w_addr_o,
   output logic                     pending_w_addr_bypass_hash_o,
   output logic                     pending_up_o,
   output logic                     pending_down_o,
   output logic                     pending_clear_o,

   output logic                     stall_o,
   output logic                     empty_o
);

   localparam int stall_w_lp = $clog2(stall_limit_p + 1);

   logic                     mem_fifo_v_li, mem_fifo_ready_lo, mem_fifo_v_lo, mem_fifo_yumi_li;
   logic [paddr_width_p:0]   mem_fifo_data_lo, mem_head;
   logic                     ack_fifo_v_li, ack_fifo_ready_lo, ack_fifo_v_lo, ack_fifo_yumi_li;
   logic [paddr_width_p-1:0] ack_fifo_data_lo, ack_head;

   logic                     mem_in_v, ack_in_v, mem_avail, ack_avail, clr_avail, load_en;
   logic [paddr_width_p-1:0] clr_head;
   bp_pending_src_e          sel;

   logic                     clr_v_q, clr_v_d;
   logic [paddr_width_p-1:0] clr_addr_q, clr_addr_d;
   logic                     out_v_q, out_v_d;
   bp_pending_w_cmd_s        out_q, out_d;
   bp_pending_rr_e           rr_q, rr_d;
   logic [stall_w_lp-1:0]    stall_cnt_q, stall_cnt_d;

   bsg_fifo_1r1w_small #(.width_p(paddr_width_p + 1), .els_p(buf_els_p)) mem_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (mem_fifo_v_li),
      .ready_o (mem_fifo_ready_lo),
      .data_i  ({mem_done_bypass_hash_i, mem_done_addr_i}),
      .v_o     (mem_fifo_v_lo),
      .data_o  (mem_fifo_data_lo),
      .yumi_i  (mem_fifo_yumi_li)
   );

   bsg_fifo_1r1w_small #(.width_p(paddr_width_p), .els_p(buf_els_p)) ack_fifo (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .v_i     (ack_fifo_v_li),
      .ready_o (ack_fifo_ready_lo),
      .data_i  (ack_done_addr_i),
      .v_o     (ack_fifo_v_lo),
      .data_o  (ack_fifo_data_lo),
      .yumi_i  (ack_fifo_yumi_li)
   );

   assign mem_done_ready_and_o = mem_fifo_ready_lo;
   assign ack_done_ready_and_o = ack_fifo_ready_lo;
   assign clear_ready_and_o    = ~clr_v_q;

   // An empty source's incoming request is a candidate in its arrival cycle,
   // loading straight into the output register instead of through the buffer.
   always_comb begin
      mem_in_v  = mem_done_v_i & mem_fifo_ready_lo;
      ack_in_v  = ack_done_v_i & ack_fifo_ready_lo;
      mem_avail = mem_fifo_v_lo | mem_in_v;
      ack_avail = ack_fifo_v_lo | ack_in_v;
      clr_avail = clr_v_q | clear_v_i;
      mem_head  = mem_fifo_v_lo ? mem_fifo_data_lo : {mem_done_bypass_hash_i, mem_done_addr_i};
      ack_head  = ack_fifo_v_lo ? ack_fifo_data_lo : ack_done_addr_i;
      clr_head  = clr_v_q ? clr_addr_q : clear_addr_i;
      load_en   = ~out_v_q | pending_w_yumi_i;

      sel = e_src_none;
      if (load_en) begin
         if (clr_avail) begin
            sel = e_src_clear;
         end else if (mem_avail && (rr_q == e_rr_mem || !ack_avail)) begin
            sel = e_src_mem;
         end else if (ack_avail) begin
            sel = e_src_ack;
         end
      end

      out_v_d = out_v_q & ~pending_w_yumi_i;
      out_d   = out_q;
      rr_d    = rr_q;
      case (sel)
         e_src_clear: begin
            out_v_d = 1'b1;
            out_d   = '{addr: paddr_width_gp'(clr_head), bypass_hash: 1'b0,
                        up: 1'b0, down: 1'b0, clear: 1'b1};
         end
         e_src_mem: begin
            out_v_d = 1'b1;
            out_d   = '{addr: paddr_width_gp'(mem_head[paddr_width_p-1:0]),
                        bypass_hash: mem_head[paddr_width_p],
                        up: 1'b0, down: 1'b1, clear: 1'b0};
            rr_d    = (rr_q == e_rr_mem) ? e_rr_ack : e_rr_mem;
         end
         e_src_ack: begin
            out_v_d = 1'b1;
            out_d   = '{addr: paddr_width_gp'(ack_head), bypass_hash: 1'b0,
                        up: 1'b0, down: 1'b1, clear: 1'b0};
            rr_d    = (rr_q == e_rr_mem) ? e_rr_ack : e_rr_mem;
         end
         default: ;
      endcase

      mem_fifo_yumi_li = (sel == e_src_mem) & mem_fifo_v_lo;
      mem_fifo_v_li    = mem_in_v & ~((sel == e_src_mem) & ~mem_fifo_v_lo);
      ack_fifo_yumi_li = (sel == e_src_ack) & ack_fifo_v_lo;
      ack_fifo_v_li    = ack_in_v & ~((sel == e_src_ack) & ~ack_fifo_v_lo);

      clr_v_d    = clr_v_q;
      clr_addr_d = clr_addr_q;
      if (clr_v_q) begin
         if (sel == e_src_clear) clr_v_d = 1'b0;
      end else if (clear_v_i && sel != e_src_clear) begin
         clr_v_d    = 1'b1;
         clr_addr_d = clear_addr_i;
      end

      stall_cnt_d = '0;
      if (out_v_q && !pending_w_yumi_i) begin
         stall_cnt_d = (stall_cnt_q == stall_w_lp'(stall_limit_p))
                       ? stall_cnt_q : stall_cnt_q + stall_w_lp'(1);
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         clr_v_q     <= 1'b0;
         clr_addr_q  <= '0;
         out_v_q     <= 1'b0;
         out_q       <= '0;
         rr_q        <= e_rr_mem;
         stall_cnt_q <= '0;
      end else begin
         clr_v_q     <= clr_v_d;
         clr_addr_q  <= clr_addr_d;
         out_v_q     <= out_v_d;
         out_q       <= out_d;
         rr_q        <= rr_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign pending_w_v_o                = out_v_q;
   assign pending_w_addr_o             = paddr_width_p'(out_q.addr);
   assign pending_w_addr_bypass_hash_o = out_q.bypass_hash;
   assign pending_up_o                 = out_q.up;
   assign pending_down_o               = out_q.down;
   assign pending_clear_o              = out_q.clear;
   assign stall_o                      = (stall_cnt_q == stall_w_lp'(stall_limit_p));
   assign empty_o = ~mem_fifo_v_lo & ~ack_fifo_v_lo & ~clr_v_q & ~out_v_q;

   // Consuming a write that is not being offered is a protocol violation.
   yumi_while_idle: assert property (@(posedge clk_i) disable iff (reset_i)
      pending_w_yumi_i |-> out_v_q);

endmodule

// File: tb/tb_bp_cce_hybrid_pending_release.sv
// Directed bench for the pending-release merger: reset, latency, round-robin
// streaming, clear priority, stall counter and asynchronous reset.
module tb_bp_cce_hybrid_pending_release;

   localparam int aw = 40;

   logic          clk_i = 1'b0;
   logic          reset_i;
   logic          mem_done_v_i, mem_done_ready_and_o, mem_done_bypass_hash_i;
   logic [aw-1:0] mem_done_addr_i;
   logic          ack_done_v_i, ack_done_ready_and_o;
   logic [aw-1:0] ack_done_addr_i;
   logic          clear_v_i, clear_ready_and_o;
   logic [aw-1:0] clear_addr_i;
   logic          pending_w_v_o, pending_w_yumi_i;
   logic [aw-1:0] pending_w_addr_o;
   logic          pending_w_addr_bypass_hash_o, pending_up_o, pending_down_o, pending_clear_o;
   logic          stall_o, empty_o;

   logic          yumi_en;
   int            n_vec = 0;
   int            n_err = 0;
   logic [aw-1:0] exp_q[$];
   logic [aw-1:0] got_q[$];
   int            cyc_q[$];

   always #5 clk_i = ~clk_i;

   // The consumer takes every offered write while enabled.
   assign pending_w_yumi_i = yumi_en & pending_w_v_o;

   bp_cce_hybrid_pending_release #(.paddr_width_p(aw), .buf_els_p(2), .stall_limit_p(64)) dut (
      .clk_i                        (clk_i),
      .reset_i                      (reset_i),
      .mem_done_v_i                 (mem_done_v_i),
      .mem_done_ready_and_o         (mem_done_ready_and_o),
      .mem_done_addr_i              (mem_done_addr_i),
      .mem_done_bypass_hash_i       (mem_done_bypass_hash_i),
      .ack_done_v_i                 (ack_done_v_i),
      .ack_done_ready_and_o         (ack_done_ready_and_o),
      .ack_done_addr_i              (ack_done_addr_i),
      .clear_v_i                    (clear_v_i),
      .clear_ready_and_o            (clear_ready_and_o),
      .clear_addr_i                 (clear_addr_i),
      .pending_w_v_o                (pending_w_v_o),
      .pending_w_yumi_i             (pending_w_yumi_i),
      .pending_w_addr_o             (pending_w_addr_o),
      .pending_w_addr_bypass_hash_o (pending_w_addr_bypass_hash_o),
      .pending_up_o                 (pending_up_o),
      .pending_down_o               (pending_down_o),
      .pending_clear_o              (pending_clear_o),
      .stall_o                      (stall_o),
      .empty_o                      (empty_o)
   );

   task automatic check1(input string tag, input logic obs, input logic exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic checka(input string tag, input logic [aw-1:0] obs, input logic [aw-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic checki(input string tag, input int obs, input int exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic idle_inputs();
      mem_done_v_i           = 1'b0;
      mem_done_addr_i        = '0;
      mem_done_bypass_hash_i = 1'b0;
      ack_done_v_i           = 1'b0;
      ack_done_addr_i        = '0;
      clear_v_i              = 1'b0;
      clear_addr_i           = '0;
   endtask

   task automatic do_reset();
      reset_i = 1'b1;
      tick();
      tick();
      reset_i = 1'b0;
      tick();
   endtask

   initial begin
      int  mi, ai, bad, seen;
      logic m_acc, a_acc;

      yumi_en = 1'b0;
      idle_inputs();
      reset_i = 1'b1;
      #12;
      check1("rst_v", pending_w_v_o, 1'b0);
      check1("rst_empty", empty_o, 1'b1);
      check1("rst_stall", stall_o, 1'b0);
      @(posedge clk_i);
      #1 reset_i = 1'b0;
      tick();
      check1("rst_mem_rdy", mem_done_ready_and_o, 1'b1);
      check1("rst_ack_rdy", ack_done_ready_and_o, 1'b1);
      check1("rst_clr_rdy", clear_ready_and_o, 1'b1);

      // Single mem_done: visible the cycle after acceptance, never combinationally.
      yumi_en                = 1'b1;
      mem_done_v_i           = 1'b1;
      mem_done_addr_i        = 40'h00_8000_0040;
      mem_done_bypass_hash_i = 1'b0;
      #1;
      check1("lat_no_comb", pending_w_v_o, 1'b0);
      tick();
      idle_inputs();
      check1("lat_v", pending_w_v_o, 1'b1);
      checka("lat_addr", pending_w_addr_o, 40'h00_8000_0040);
      check1("lat_down", pending_down_o, 1'b1);
      check1("lat_clear", pending_clear_o, 1'b0);
      check1("lat_up", pending_up_o, 1'b0);
      tick();
      check1("lat_v_done", pending_w_v_o, 1'b0);
      check1("lat_empty", empty_o, 1'b1);

      // Both sources stream four entries; writes alternate mem/ack back to back.
      do_reset();
      exp_q = '{40'h100, 40'h1100, 40'h200, 40'h1200, 40'h300, 40'h1300, 40'h400, 40'h1400};
      got_q.delete();
      cyc_q.delete();
      mi  = 0;
      ai  = 0;
      bad = 0;
      for (int c = 0; c < 12; c++) begin
         mem_done_v_i    = (mi < 4);
         mem_done_addr_i = aw'(mi + 1) << 8;
         ack_done_v_i    = (ai < 4);
         ack_done_addr_i = 40'h1000 + (aw'(ai + 1) << 8);
         m_acc = mem_done_v_i & mem_done_ready_and_o;
         a_acc = ack_done_v_i & ack_done_ready_and_o;
         tick();
         if (m_acc) mi++;
         if (a_acc) ai++;
         if (pending_w_v_o) begin
            got_q.push_back(pending_w_addr_o);
            cyc_q.push_back(c);
            if (pending_down_o !== 1'b1 || pending_clear_o !== 1'b0) bad++;
         end
      end
      idle_inputs();
      checki("rr_count", got_q.size(), 8);
      for (int i = 0; i < 8; i++) begin
         checka($sformatf("rr_order_%0d", i), (i < got_q.size()) ? got_q[i] : '1, exp_q[i]);
      end
      checki("rr_back_to_back", (got_q.size() == 8) ? cyc_q[7] - cyc_q[0] : -1, 7);
      checki("rr_cmd_bits", bad, 0);
      check1("rr_empty", empty_o, 1'b1);

      // Clear jumps ahead of buffered mem/ack traffic without moving the pointer.
      yumi_en                = 1'b0;
      mem_done_v_i           = 1'b1;
      mem_done_addr_i        = 40'hA00;
      ack_done_v_i           = 1'b1;
      ack_done_addr_i        = 40'hB00;
      tick();
      idle_inputs();
      mem_done_v_i           = 1'b1;
      mem_done_addr_i        = 40'hA10;
      mem_done_bypass_hash_i = 1'b1;
      tick();
      idle_inputs();
      clear_v_i              = 1'b1;
      clear_addr_i           = 40'h2000;
      tick();
      idle_inputs();
      check1("clr_rdy_busy", clear_ready_and_o, 1'b0);
      checka("clr_hold_addr", pending_w_addr_o, 40'hA00);
      yumi_en = 1'b1;
      tick();
      checka("clr_first_addr", pending_w_addr_o, 40'h2000);
      check1("clr_first_clear", pending_clear_o, 1'b1);
      check1("clr_first_down", pending_down_o, 1'b0);
      tick();
      checka("clr_then_ack", pending_w_addr_o, 40'hB00);
      check1("clr_ack_bypass", pending_w_addr_bypass_hash_o, 1'b0);
      tick();
      checka("clr_then_mem", pending_w_addr_o, 40'hA10);
      check1("clr_mem_bypass", pending_w_addr_bypass_hash_o, 1'b1);
      tick();
      check1("clr_drained", empty_o, 1'b1);

      // Stall: pointer is at ack here, so D00 goes straight to the output.
      yumi_en         = 1'b0;
      mem_done_v_i    = 1'b1;
      mem_done_addr_i = 40'hC00;
      ack_done_v_i    = 1'b1;
      ack_done_addr_i = 40'hD00;
      tick();
      mem_done_addr_i = 40'hC10;
      ack_done_addr_i = 40'hD10;
      tick();
      mem_done_v_i    = 1'b0;
      ack_done_addr_i = 40'hD20;
      tick();
      idle_inputs();
      check1("stall_mem_full", mem_done_ready_and_o, 1'b0);
      check1("stall_ack_full", ack_done_ready_and_o, 1'b0);
      bad = 0;
      for (int k = 3; k <= 70; k++) begin
         tick();
         if (pending_w_v_o !== 1'b1 || pending_w_addr_o !== 40'hD00) bad++;
         if (k == 63) check1("stall_pre", stall_o, 1'b0);
         if (k == 64) check1("stall_rise", stall_o, 1'b1);
      end
      checki("stall_stable", bad, 0);
      check1("stall_sat", stall_o, 1'b1);
      yumi_en = 1'b1;
      tick();
      check1("stall_release", stall_o, 1'b0);
      checka("stall_next", pending_w_addr_o, 40'hC00);
      seen = 0;
      for (int k = 0; k < 10 && !empty_o; k++) begin
         tick();
         seen++;
      end
      check1("stall_drain", empty_o, 1'b1);

      // Asynchronous reset with three entries buffered drops everything.
      yumi_en         = 1'b0;
      mem_done_v_i    = 1'b1;
      mem_done_addr_i = 40'hE00;
      ack_done_v_i    = 1'b1;
      ack_done_addr_i = 40'hE10;
      tick();
      ack_done_v_i    = 1'b0;
      mem_done_addr_i = 40'hE20;
      tick();
      idle_inputs();
      check1("ar_busy_empty", empty_o, 1'b0);
      check1("ar_busy_v", pending_w_v_o, 1'b1);
      #2 reset_i = 1'b1;
      #1;
      check1("ar_v", pending_w_v_o, 1'b0);
      check1("ar_empty", empty_o, 1'b1);
      check1("ar_stall", stall_o, 1'b0);
      tick();
      reset_i = 1'b0;
      yumi_en = 1'b1;
      seen    = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         if (pending_w_v_o) seen++;
      end
      checki("ar_no_stale", seen, 0);
      check1("ar_mem_rdy", mem_done_ready_and_o, 1'b1);
      check1("ar_ack_rdy", ack_done_ready_and_o, 1'b1);
      check1("ar_empty_after", empty_o, 1'b1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
